fifo_drain_ctrl: RTL and testbench
==================================

# fifo_drain_ctrl

Single-clock read-side controller that empties the asynchronous FIFO into a busy-handshake consumer (e.g. UART TX) in the read clock domain. Watches EMPTY, captures the head word, issues a one-cycle R_INC pop, presents the word with TX_VALID until the consumer acknowledges via TX_BUSY, then waits for completion and an optional inter-word gap. Sits between the FIFO read port and the serializer.

## Interface
- DATA_WIDTH, 8, FIFO/consumer word width
- GAP_CYCLES, 2, idle cycles inserted after TX_BUSY falls before the next pop (0 = none)
- CNT_WIDTH, 16, width of the sent-word counter
- CLK  input  1  read-domain clock; all logic on rising edge
- RST  input  1  asynchronous, active-low reset
- EMPTY  input  1  FIFO empty flag, already synchronous to CLK
- RD_DATA  input  DATA_WIDTH  FIFO head word, valid combinationally whenever EMPTY=0
- R_INC  output  1  registered pop strobe to FIFO, exactly one cycle per word
- TX_BUSY  input  1  consumer busy; rising = word accepted, falling = word done
- TX_DATA  output  DATA_WIDTH  registered word to consumer, stable while TX_VALID=1
- TX_VALID  output  1  registered word-valid to consumer
- SENT_CNT  output  CNT_WIDTH  words acknowledged since reset, wraps modulo 2^CNT_WIDTH

## Operation
- States: IDLE, SEND, WAIT_DONE, GAP.
- IDLE: if EMPTY=0 and TX_BUSY=0, capture RD_DATA into TX_DATA, set R_INC=1 and TX_VALID=1 for the next cycle, go SEND. Otherwise stay; R_INC=0, TX_VALID=0.
- SEND: R_INC returns to 0 (one-cycle pulse). TX_VALID held, TX_DATA held. When TX_BUSY=1 sampled: TX_VALID=0 next cycle, SENT_CNT+1, go WAIT_DONE. No timeout: holds indefinitely.
- WAIT_DONE: wait for TX_BUSY=0; then GAP if GAP_CYCLES>0 (load gap counter with GAP_CYCLES-1), else IDLE.
- GAP: decrement each cycle; at 0 go IDLE. EMPTY ignored here.
- Gap counter width: $clog2(GAP_CYCLES+1), minimum 1; unused when GAP_CYCLES=0.
- EMPTY rising while in SEND/WAIT_DONE/GAP: no effect; popped word is still delivered.
- TX_BUSY already high in IDLE with EMPTY=0: no pop until it falls.
- TX_BUSY high in same cycle TX_VALID first rises: counts as acceptance on that sampling edge (SEND exits after one cycle).
- Reset (any state, any time): state=IDLE, R_INC=0, TX_VALID=0, TX_DATA=0, SENT_CNT=0, gap counter=0. A word popped but not yet accepted is dropped.

## Timing
- EMPTY=0 sampled on edge N (in IDLE) -> R_INC=1 and TX_VALID=1 during cycle N+1; R_INC=0 from N+2.
- FIFO pointer advances on the edge ending cycle N+1; EMPTY may update from N+2 onward (sync latency is the FIFO's).
- TX_VALID falls one cycle after TX_BUSY=1 is sampled; SENT_CNT updates on that same edge.
- Earliest next pop: GAP_CYCLES+1 cycles after TX_BUSY=0 is sampled (IDLE sample edge included).
- Minimum back-to-back period with an instant consumer (BUSY 1 cycle): 4 + GAP_CYCLES cycles per word.
- All outputs registered; no combinational input-to-output path.

## Structure
- Package fifo_drain_pkg: state encoding localparams (IDLE=2'd0, SEND=2'd1, WAIT_DONE=2'd2, GAP=2'd3) and gap-counter width function.
- One natural sub-module: drain_gap_timer (load, decrement, zero flag), instantiated only when GAP_CYCLES>0.
- FSM, data register, and SENT_CNT in the top module.

## Test plan
- Reset with EMPTY=0, RD_DATA=8'hA5 -> during reset all outputs 0; after release, R_INC pulses exactly one cycle and TX_DATA=8'hA5 with TX_VALID=1 on cycle 2.
- FIFO preloaded 8'h01..8'h08, consumer BUSY 10 cycles per word, GAP_CYCLES=2 -> 8 R_INC pulses, TX_DATA sequence 01..08, SENT_CNT=8, ≥3 idle cycles between BUSY fall and next R_INC, idle once EMPTY=1.
- TX_BUSY held 1 before any data, EMPTY=0 -> no R_INC until BUSY falls, then pop on the following cycle.
- Consumer delays BUSY 50 cycles after TX_VALID -> TX_VALID and TX_DATA stable all 50 cycles, no extra R_INC.
- Reset asserted in WAIT_DONE after 3 words -> SENT_CNT=0, TX_VALID=0 immediately (async); FIFO read resumes cleanly after release.
- CNT_WIDTH=4, 17 words sent -> SENT_CNT wraps to 4'd1.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared state encoding and sizing helpers for the FIFO drain controller
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } drain_state_t;

    // $clog2(1) is 0, so a zero or one-cycle gap still gets a one-bit counter.
    function automatic int gap_cnt_width(input int gap_cycles);
        int w;
        w = $clog2(gap_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/drain_gap_timer.sv
// rtl/drain_gap_timer.sv - loadable down-counter timing the idle gap between drained words
module drain_gap_timer #(
    parameter int WIDTH    = 2,
    parameter int LOAD_VAL = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= WIDTH'(LOAD_VAL);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - pops the FIFO head and hands each word to a busy-handshake consumer
module fifo_drain_ctrl
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_empty,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_r_inc,
    input  logic                  i_tx_busy,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    output logic [CNT_WIDTH-1:0]  o_sent_cnt
);

    localparam int GAP_W = gap_cnt_width(GAP_CYCLES);

    drain_state_t          r_state;
    drain_state_t          w_next;
    logic                  w_pop;
    logic                  w_accept;
    logic                  w_gap_load;
    logic                  w_gap_zero;
    logic                  r_r_inc;
    logic                  r_tx_valid;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [CNT_WIDTH-1:0]  r_sent_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_accept   = 1'b0;
        w_gap_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (!i_empty && !i_tx_busy) begin
                    w_pop  = 1'b1;
                    w_next = SEND;
                end
            end
            SEND: begin
                if (i_tx_busy) begin
                    w_accept = 1'b1;
                    w_next   = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    if (GAP_CYCLES > 0) begin
                        w_gap_load = 1'b1;
                        w_next     = GAP;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            GAP: begin
                if (w_gap_zero) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    generate
        if (GAP_CYCLES > 0) begin : g_gap
            drain_gap_timer #(
                .WIDTH    (GAP_W),
                .LOAD_VAL (GAP_CYCLES - 1)
            ) u_gap_timer (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_load  (w_gap_load),
                .i_dec   (r_state == GAP),
                .o_zero  (w_gap_zero)
            );
        end else begin : g_no_gap
            assign w_gap_zero = 1'b1;
        end
    endgenerate

    // The popped word stays in r_tx_data until the next pop, so it holds while valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_r_inc    <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_sent_cnt <= '0;
        end else begin
            r_r_inc <= w_pop;
            if (w_pop) begin
                r_tx_data  <= i_rd_data;
                r_tx_valid <= 1'b1;
            end else if (w_accept) begin
                r_tx_valid <= 1'b0;
            end
            if (w_accept) begin
                r_sent_cnt <= r_sent_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign o_r_inc    = r_r_inc;
    assign o_tx_valid = r_tx_valid;
    assign o_tx_data  = r_tx_data;
    assign o_sent_cnt = r_sent_cnt;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb/tb_fifo_drain_ctrl.sv - scoreboard bench for fifo_drain_ctrl with a FIFO model and scripted consumer
module tb_fifo_drain_ctrl;

    localparam int DW  = 8;
    localparam int GAP = 2;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          empty;
    logic [DW-1:0] rd_data;
    logic          r_inc;
    logic          tx_busy;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic [CW-1:0] sent_cnt;

    logic [DW-1:0] mem [0:63];
    logic [6:0]    wr_ptr = '0;
    logic [6:0]    rd_ptr = '0;
    logic [DW-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    fifo_drain_ctrl #(
        .DATA_WIDTH (DW),
        .GAP_CYCLES (GAP),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_empty    (empty),
        .i_rd_data  (rd_data),
        .o_r_inc    (r_inc),
        .i_tx_busy  (tx_busy),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .o_sent_cnt (sent_cnt)
    );

    always #5 clk = ~clk;

    assign empty   = (wr_ptr == rd_ptr);
    assign rd_data = empty ? '0 : mem[rd_ptr[5:0]];

    task automatic check(input string name, input bit pass, input int act, input int req);
        checks++;
        if (!pass) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // FIFO read pointer advances while the pop strobe is high.
    always @(negedge clk) begin
        if (rst_n && r_inc) rd_ptr = rd_ptr + 7'd1;
    end

    logic          prev_valid = 1'b0;
    logic          prev_rinc  = 1'b0;
    logic          prev_busy  = 1'b0;
    logic          in_word    = 1'b0;
    logic          armed      = 1'b0;
    int            since      = 0;
    logic [DW-1:0] held       = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_rinc  = 1'b0;
            in_word    = 1'b0;
            armed      = 1'b0;
            prev_busy  = tx_busy;
        end else begin
            if (armed) since++;
            if (r_inc) begin
                pulse_cnt++;
                check("rinc_one_cycle", !prev_rinc, prev_rinc, 0);
                if (armed) begin
                    check("gap_before_pop", since >= GAP + 2, since, GAP + 2);
                    armed = 1'b0;
                end
            end
            if (tx_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1'b0, tx_data, 0);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    check("word_data", tx_data == e, tx_data, e);
                end
                check("valid_with_rinc", r_inc, r_inc, 1);
                held    = tx_data;
                in_word = 1'b1;
            end else if (tx_valid) begin
                check("data_hold", tx_data == held, tx_data, held);
            end
            if (prev_busy && !tx_busy && in_word) begin
                armed   = 1'b1;
                since   = 0;
                in_word = 1'b0;
            end
            prev_valid = tx_valid;
            prev_rinc  = r_inc;
            prev_busy  = tx_busy;
        end
    end

    task automatic push(input logic [DW-1:0] d);
        mem[wr_ptr[5:0]] = d;
        wr_ptr = wr_ptr + 7'd1;
        exp_q.push_back(d);
    endtask

    task automatic wait_valid(output bit ok);
        int t = 0;
        while (!tx_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        ok = tx_valid;
        if (!ok) check("valid_timeout", 1'b0, 0, 1);
    endtask

    task automatic serve(input int dly, input int len);
        bit ok;
        wait_valid(ok);
        if (ok) begin
            repeat (dly) @(posedge clk);
            @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (len) @(posedge clk);
            #1 tx_busy = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        bit ok;
        rst_n   = 1'b0;
        tx_busy = 1'b0;

        repeat (3) @(posedge clk);
        #1 push(8'hA5);
        @(negedge clk);
        check("rst_rinc",  r_inc == 0,    r_inc,    0);
        check("rst_valid", tx_valid == 0, tx_valid, 0);
        check("rst_data",  tx_data == 0,  tx_data,  0);
        check("rst_cnt",   sent_cnt == 0, sent_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("first_rinc_c0", r_inc == 0, r_inc, 0);
        @(negedge clk);
        check("first_rinc_c1",  r_inc == 1,       r_inc,    1);
        check("first_valid_c1", tx_valid == 1,    tx_valid, 1);
        check("first_data_c1",  tx_data == 8'hA5, tx_data,  8'hA5);
        @(negedge clk);
        check("first_rinc_c2",  r_inc == 0,    r_inc,    0);
        check("first_valid_c2", tx_valid == 1, tx_valid, 1);
        serve(0, 3);

        @(posedge clk);
        #1;
        for (int i = 1; i <= 8; i++) push(DW'(i));
        for (int i = 0; i < 8; i++) serve(0, 10);
        repeat (10) @(negedge clk);
        check("burst_cnt",    sent_cnt == 4'd9, sent_cnt,  9);
        check("burst_pulses", pulse_cnt == 9,   pulse_cnt, 9);
        check("burst_idle_v", tx_valid == 0,    tx_valid,  0);
        check("burst_idle_r", r_inc == 0,       r_inc,     0);

        @(posedge clk);
        #1 tx_busy = 1'b1;
        push(8'h3C);
        repeat (5) @(negedge clk);
        check("busy_hold_pulses", pulse_cnt == 9, pulse_cnt, 9);
        check("busy_hold_valid",  tx_valid == 0,  tx_valid,  0);
        @(posedge clk);
        #1 tx_busy = 1'b0;
        @(negedge clk);
        check("busy_fall_c0", r_inc == 0, r_inc, 0);
        @(negedge clk);
        check("busy_fall_c1", r_inc == 1, r_inc, 1);
        serve(0, 2);

        @(posedge clk);
        #1 push(8'h5A);
        serve(50, 2);
        repeat (3) @(negedge clk);
        check("slow_pulses", pulse_cnt == 11,   pulse_cnt, 11);
        check("slow_cnt",    sent_cnt == 4'd11, sent_cnt,  11);

        @(posedge clk);
        #1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        serve(0, 3);
        serve(0, 3);
        wait_valid(ok);
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_cnt", sent_cnt == 4'd14, sent_cnt, 14);
        rst_n   = 1'b0;
        tx_busy = 1'b0;
        #1;
        check("async_rst_cnt",   sent_cnt == 0, sent_cnt, 0);
        check("async_rst_valid", tx_valid == 0, tx_valid, 0);
        push(8'h44);
        repeat (3) @(negedge clk);
        check("in_rst_rinc", r_inc == 0, r_inc, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        serve(0, 3);
        repeat (3) @(negedge clk);
        check("post_rst_cnt", sent_cnt == 4'd1, sent_cnt, 1);

        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) push(DW'(8'h80 + i));
        for (int i = 0; i < 16; i++) begin
            serve(0, 1);
            if (i == 13) check("cnt_15",   sent_cnt == 4'd15, sent_cnt, 15);
            if (i == 14) check("cnt_wrap", sent_cnt == 4'd0,  sent_cnt, 0);
            if (i == 15) check("cnt_17",   sent_cnt == 4'd1,  sent_cnt, 1);
        end

        repeat (10) @(negedge clk);
        check("all_delivered", exp_q.size() == 0, exp_q.size(), 0);
        check("final_idle",    tx_valid == 0,     tx_valid,     0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
